// File: rtl/otf_pkg.sv
// Shared types and digit encodings for the signed-digit to two's-complement
// on-the-fly converter.
package otf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } otf_state_e;

  // Digit rails are {d_plus, d_minus}; both rails high cancel to zero.
  localparam logic [1:0] DIGIT_POS      = 2'b10;
  localparam logic [1:0] DIGIT_NEG      = 2'b01;
  localparam logic [1:0] DIGIT_ZERO     = 2'b00;
  localparam logic [1:0] DIGIT_ZERO_ALT = 2'b11;

endpackage

// File: rtl/otf_step.sv
// One-digit on-the-fly update of the Q/QM pair; pure shift/concatenate logic,
// so the QM = Q-1 relation is kept without any carry chain.
module otf_step
  import otf_pkg::*;
#(
  parameter int width = 5
) (
  input  logic [width-1:0] q,
  input  logic [width-1:0] qm,
  input  logic [1:0]       digit,
  output logic [width-1:0] q_next,
  output logic [width-1:0] qm_next
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  // Select the shifted source and appended bit for each digit value
  always_comb begin
    q_next  = q;
    qm_next = qm;
    case (digit)
      DIGIT_POS: begin
        q_next  = (q << 1) | ONE;
        qm_next = (q << 1);
      end
      DIGIT_NEG: begin
        q_next  = (qm << 1) | ONE;
        qm_next = (qm << 1);
      end
      DIGIT_ZERO, DIGIT_ZERO_ALT: begin
        q_next  = (q << 1);
        qm_next = (qm << 1) | ONE;
      end
      default: begin
        q_next  = (q << 1);
        qm_next = (qm << 1) | ONE;
      end
    endcase
  end

endmodule

// File: rtl/sd_to_binary_otf.sv
// Serial MSD-first signed-digit to two's-complement converter with a
// valid/ready handshake on both sides and a one-cycle result latency.
module sd_to_binary_otf
  import otf_pkg::*;
#(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            d_plus,
  input  logic            d_minus,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [bits:0]   z,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int W  = bits + 1;
  localparam int CW = $clog2(bits) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(bits - 1);

  otf_state_e    state_r;
  logic [W-1:0]  q_r;
  logic [W-1:0]  qm_r;
  logic [CW-1:0] cnt_r;
  logic          out_valid_r;
  logic          rdy_r;

  logic          start_s;
  logic          accept_s;
  logic          last_s;
  logic          in_ready_s;
  logic [W-1:0]  q_base_s;
  logic [W-1:0]  qm_base_s;
  logic [CW-1:0] cnt_base_s;
  logic [W-1:0]  q_next_s;
  logic [W-1:0]  qm_next_s;

  // Handshake and word-start selection; a fresh word always starts from Q=0/QM=-1
  always_comb begin
    in_ready_s = 1'b0;
    if (!rdy_r) begin
      in_ready_s = 1'b0;
    end else if (state_r == DONE) begin
      in_ready_s = out_ready;
    end else begin
      in_ready_s = 1'b1;
    end

    start_s = (state_r != ACC);
    if (start_s) begin
      q_base_s   = '0;
      qm_base_s  = '1;
      cnt_base_s = '0;
    end else begin
      q_base_s   = q_r;
      qm_base_s  = qm_r;
      cnt_base_s = cnt_r;
    end

    accept_s = in_valid && in_ready_s;
    last_s   = (cnt_base_s == LAST_CNT);
  end

  otf_step #(
    .width (W)
  ) u_step (
    .q       (q_base_s),
    .qm      (qm_base_s),
    .digit   ({d_plus, d_minus}),
    .q_next  (q_next_s),
    .qm_next (qm_next_s)
  );

  // Control FSM, digit counter and Q/QM registers; clear acts as the soft reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      q_r         <= '0;
      qm_r        <= '1;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      rdy_r       <= 1'b0;
    end else if (clear) begin
      state_r     <= IDLE;
      q_r         <= '0;
      qm_r        <= '1;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      rdy_r       <= 1'b1;
    end else begin
      rdy_r <= 1'b1;
      if (accept_s) begin
        q_r  <= q_next_s;
        qm_r <= qm_next_s;
        if (last_s) begin
          state_r     <= DONE;
          cnt_r       <= '0;
          out_valid_r <= 1'b1;
        end else begin
          state_r     <= ACC;
          cnt_r       <= cnt_base_s + CW'(1);
          out_valid_r <= 1'b0;
        end
      end else if ((state_r == DONE) && out_ready) begin
        state_r     <= IDLE;
        cnt_r       <= '0;
        out_valid_r <= 1'b0;
      end else begin
        state_r     <= state_r;
        cnt_r       <= cnt_r;
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign z         = q_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sd_to_binary_otf.sv
// Directed bench for sd_to_binary_otf (bits=4) with an arithmetic reference
// model feeding a result scoreboard.
module tb_sd_to_binary_otf;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       d_plus;
  logic       d_minus;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] z;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int failures;
  logic [4:0] sb_q[$];

  localparam logic [7:0] W_P7   = 8'b10_00_01_10;
  localparam logic [7:0] W_M15  = 8'b01_01_01_01;
  localparam logic [7:0] W_P1   = 8'b10_01_01_01;
  localparam logic [7:0] W_ZERO = 8'b11_11_11_11;
  localparam logic [7:0] W_P11  = 8'b10_10_00_01;
  localparam logic [7:0] W_P15  = 8'b10_10_10_10;

  sd_to_binary_otf #(.bits(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input logic [7:0] w);
    int s;
    logic [1:0] dg;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      dg = w[7-2*i -: 2];
      if (dg == 2'b10) s += (1 << (3 - i));
      else if (dg == 2'b01) s -= (1 << (3 - i));
    end
    return s[4:0];
  endfunction

  task automatic sb_check();
    logic [4:0] exp;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", sb_q.size(), 1);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_z", z, exp);
      end
    end
  endtask

  task automatic clk_cycle();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [1:0] dg, output int waited);
    logic acc;
    d_plus   = dg[1];
    d_minus  = dg[0];
    in_valid = 1'b1;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      sb_check();
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic send_word(input logic [7:0] w, output int cycles);
    int n;
    cycles = 0;
    for (int i = 0; i < 4; i++) begin
      send_digit(w[7-2*i -: 2], n);
      cycles += n;
    end
    sb_q.push_back(model(w));
  endtask

  initial begin
    int c1;
    int c2;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    d_plus    = 1'b0;
    d_minus   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset values and in_ready release
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_high", in_ready, 1);

    // +7 with latency check, then the other spec words
    send_word(W_P7, c1);
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_z_p7", z, 5'b00111);
    clk_cycle();
    send_word(W_M15, c1);
    in_valid = 1'b0;
    chk("z_m15", z, 5'b10001);
    clk_cycle();
    send_word(W_P1, c1);
    in_valid = 1'b0;
    clk_cycle();
    send_word(W_ZERO, c1);
    in_valid = 1'b0;
    clk_cycle();

    // Back-pressure hold with a stray digit presented
    out_ready = 1'b0;
    send_word(W_P11, c1);
    d_plus  = 1'b1;
    d_minus = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_z", z, 5'b01011);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clk_cycle();
    chk("pop_in_ready", in_ready, 1);
    chk("pop_out_valid", out_valid, 0);

    // Back-to-back words with no idle cycle
    send_word(W_P7, c1);
    send_word(W_M15, c2);
    in_valid = 1'b0;
    chk("b2b_cycles", c1 + c2, 8);
    clk_cycle();

    // Clear after two digits, with an ignored digit in the clear cycle
    send_digit(2'b01, c1);
    send_digit(2'b01, c1);
    clear   = 1'b1;
    d_plus  = 1'b0;
    d_minus = 1'b1;
    clk_cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_z", z, 0);
    chk("clr_in_ready", in_ready, 1);
    send_word(W_P15, c1);
    in_valid = 1'b0;
    clk_cycle();

    // Asynchronous reset mid-word
    send_digit(2'b10, c1);
    send_digit(2'b10, c1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_z", z, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(W_P1, c1);
    in_valid = 1'b0;
    chk("post_rst_z", z, 5'b00001);
    clk_cycle();
    clk_cycle();
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
